// File: rtl/fir_serial_mac_sequencer.sv
// Time-multiplexed FIR: one shared signed MAC walks all taps per sample over a circular
// delay line, then presents a scaled, saturated result on a valid/ready output.
module fir_serial_mac_sequencer #(
  parameter int unsigned NUM_TAPS = 61,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned COEFF_W  = 16,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned SHIFT    = 15,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_sample,
  output logic        [ADDR_W-1:0]  coeff_addr,
  input  logic signed [COEFF_W-1:0] coeff_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_sample,
  output logic                      busy
);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  localparam int unsigned ProdW = DATA_W + COEFF_W;
  localparam logic [ADDR_W-1:0] LastTap  = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] NumTapsA = ADDR_W'(NUM_TAPS);
  localparam logic signed [ACC_W-1:0] SatMax =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  state_e                    state_q;
  logic        [ADDR_W-1:0]  wr_ptr_q;
  logic        [ADDR_W-1:0]  k_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [DATA_W-1:0]  dline_q [NUM_TAPS];

  logic        [ADDR_W-1:0]  rd_idx;
  logic signed [DATA_W-1:0]  rd_sample;
  logic signed [ProdW-1:0]   prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   acc_shift;
  logic signed [DATA_W-1:0]  sat_sample;

  always_comb begin
    // Wrap modulo NUM_TAPS rather than 2^ADDR_W so the delay line has no dead slots.
    if (wr_ptr_q >= k_q) begin
      rd_idx = wr_ptr_q - k_q;
    end else begin
      rd_idx = wr_ptr_q + (NumTapsA - k_q);
    end
    rd_sample = dline_q[rd_idx];
    prod      = rd_sample * coeff_data;
    acc_sum   = acc_q + {{(ACC_W - ProdW){prod[ProdW-1]}}, prod};
    acc_shift = acc_sum >>> SHIFT;
    if (acc_shift > SatMax) begin
      sat_sample = SatMax[DATA_W-1:0];
    end else if (acc_shift < SatMin) begin
      sat_sample = SatMin[DATA_W-1:0];
    end else begin
      sat_sample = acc_shift[DATA_W-1:0];
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign coeff_addr = (state_q == StMac) ? k_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        dline_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            dline_q[wr_ptr_q] <= in_sample;
            acc_q             <= '0;
            k_q               <= '0;
            state_q           <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_sum;
          if (k_q == LastTap) begin
            k_q        <= '0;
            wr_ptr_q   <= (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + 1'b1;
            out_sample <= sat_sample;
            out_valid  <= 1'b1;
            state_q    <= StDone;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
